counter_seq: RTL and testbench
==============================

# counter_seq

Sequencer for the 4-bit counter IP. On a start request it clears the counter, issues a programmed number of single-cycle `cin` pulses, optionally spaced by idle gaps, and extends the count above the IP's width by accumulating `cout` carries. It sits between control logic and the counter IP, and returns a one-cycle `done` or `aborted` completion pulse. The counter IP is generated with a synchronous-clear port, which `cnt_sclr` drives.

## Interface
- `CNT_W`, default 4: width of the counter IP `q`.
- `HI_W`, default 8: width of the carry-extension counter. Total width `L = CNT_W + HI_W`.
- `GAP_W`, default 4: width of the inter-pulse gap field.

Ports:
- `clock` in 1: single clock; everything is sampled on the rising edge.
- `sclr` in 1: synchronous, active-high reset.
- `start` in 1: job request; accepted only in IDLE.
- `len` in L: number of `cin` pulses to issue; latched at start.
- `gap` in GAP_W: idle cycles between pulses; latched at start.
- `abort` in 1: terminates the current job; ignored in IDLE.
- `cnt_q` in CNT_W: `q` from the counter IP.
- `cnt_cout` in 1: `cout` from the counter IP (combinational, high when q is all-ones and cin is high).
- `cin` out 1: count enable to the counter IP.
- `cnt_sclr` out 1: synchronous clear to the counter IP.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort.
- `total` out L: `{hi, cnt_q}`, the accumulated count.

## Operation
- FSM states are IDLE, CLR, RUN, GAP and DONE. Outputs are Moore except `cnt_sclr`.
  - `cin` = (state == RUN).
  - `cnt_sclr` = `sclr` | (state == CLR).
  - `busy` = (state != IDLE).
  - `done` = (state == DONE).
- IDLE -> CLR when `start` is high.
  - Latch `len` into `rem` and `gap` into `gap_r`.
  - Clear `hi`.
- CLR -> DONE if `rem == 0`, otherwise CLR -> RUN.
- RUN behaviour:
  - Each RUN cycle decrements `rem`.
  - If `cnt_cout` is high, `hi` increments, wrapping modulo 2^HI_W.
- RUN transitions:
  - If `rem == 1`, go to DONE.
  - Else if gap is enabled and `gap_r != 0`, go to GAP and load the gap down-counter with `gap_r`.
  - Else stay in RUN.
- GAP: decrement the gap counter; when it reaches 1, go to RUN.
- DONE -> IDLE unconditionally.
- `start` in any non-IDLE state, including DONE, is ignored. It is not queued.
- `abort` in CLR, RUN or GAP:
  - Next state is IDLE and `aborted` pulses in the following cycle.
  - A `cin` pulse in the abort cycle itself (Moore output) is still issued and still counted.
  - `done` is not asserted.
  - `abort` in DONE is ignored; `done` wins.
- `total` is combinational `{hi, cnt_q}`.
  - It is guaranteed final in the DONE cycle and holds in IDLE until the next start.
- `sclr` has priority over everything, including mid-job.
  - State goes to IDLE; `rem`, `gap_r`, `hi` and the gap counter clear.
  - `done` and `aborted` go low; `cin` goes low in the cycle after `sclr` is sampled high.
  - `cnt_sclr` is high during every `sclr` cycle.

## Timing
- Reset values: `cin` 0, `busy` 0, `done` 0, `aborted` 0, `hi` 0. `cnt_sclr` follows `sclr`.
- Cycle numbering: `start` is sampled at cycle T.
  - CLR at T+1.
  - First `cin` pulse at T+2.
  - Pulse k (0-based) at T+2+k·(g+1), where g = latched gap (0 when the feature is compiled out).
  - `done` at T+2+(len−1)·(g+1)+1.
  - With `len == 0`: `done` at T+2 and no `cin` pulse.
- No gap is inserted after the last pulse.
- `aborted` is high exactly one cycle after the abort cycle; `busy` is low in that same cycle.
- The earliest back-to-back restart is `start` in the cycle after DONE.

## Configuration
- Macro `CNT_SEQ_GAP_EN`.
- Defined:
  - The GAP state, `gap_r` and the gap down-counter are built.
  - Pulses are spaced by `gap` idle cycles.
- Undefined:
  - The GAP state and its registers are not built.
  - The `gap` port remains but is ignored.
  - `cin` is high continuously for `len` cycles.

## Test plan
- Reset: hold `sclr` for 2 cycles with `start` high -> `cnt_sclr` = 1 in both cycles; `busy`, `cin`, `done` and `aborted` = 0; no job starts.
- `len` = 20, `gap` = 0, start at T -> `cnt_sclr` at T+1; `cin` high T+2..T+21; one `cnt_cout`, so `hi` = 1; `done` at T+22; `total` = 20.
- `len` = 0 -> `busy` at T+1..T+2, `done` at T+2, no `cin`, `total` = 0.
- `CNT_SEQ_GAP_EN` defined, `len` = 3, `gap` = 2 -> `cin` at T+2, T+5, T+8; `done` at T+9; `total` = 3. Same stimulus with the macro undefined -> `cin` T+2..T+4, `done` at T+5.
- Abort on the 5th RUN cycle of a `len` = 20 job -> 5 pulses counted; `aborted` the next cycle; no `done`; `total` = 5; `start` during the job is ignored.
- `len` = 4095, `gap` = 0 -> 255 carries, `hi` = 255, `total` = 4095, `done` at T+4097.

Source files
------------

// File: rtl/counter_seq.sv
// counter_seq: job sequencer for the 4-bit counter IP.
// Clears the counter, issues a programmed number of cin pulses and extends
// the count above the IP width by accumulating cout carries into hi.
// Optional feature macro: CNT_SEQ_GAP_EN (idle gap cycles between pulses).
module counter_seq #(
    parameter int CNT_W = 4,
    parameter int HI_W  = 8,
    parameter int GAP_W = 4,
    localparam int L    = CNT_W + HI_W
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             start,
    input  logic [L-1:0]     len,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    input  logic [CNT_W-1:0] cnt_q,
    input  logic             cnt_cout,
    output logic             cin,
    output logic             cnt_sclr,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [L-1:0]     total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
`ifdef CNT_SEQ_GAP_EN
        S_GAP,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_abort_go;
    logic [L-1:0]      r_rem;
    logic [HI_W-1:0]   r_hi;
    logic              r_aborted;

`ifdef CNT_SEQ_GAP_EN
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gcnt;
`else
    // Gap field is accepted on the port but has no effect in this build.
    logic              w_unused_gap;
    assign w_unused_gap = ^gap;
`endif

    // Next-state selection; abort wins over every normal transition except in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_abort_go  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort_go  = 1'b1;
                end else if (r_rem == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort_go  = 1'b1;
                end else if (r_rem == L'(1)) begin
                    w_state_nxt = S_DONE;
`ifdef CNT_SEQ_GAP_EN
                end else if (r_gap != '0) begin
                    w_state_nxt = S_GAP;
`endif
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef CNT_SEQ_GAP_EN
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort_go  = 1'b1;
                end else if (r_gcnt == GAP_W'(1)) begin
                    w_state_nxt = S_RUN;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, remaining-pulse count, carry extension and abort pulse.
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_hi      <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_aborted <= w_abort_go;
            if (r_state == S_IDLE && start) begin
                r_rem <= len;
                r_hi  <= '0;
            end
            if (r_state == S_RUN) begin
                r_rem <= r_rem - L'(1);
                if (cnt_cout) r_hi <= r_hi + HI_W'(1);
            end
        end
    end

`ifdef CNT_SEQ_GAP_EN
    // Latched gap length and the down-counter timing each idle stretch.
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_gap  <= '0;
            r_gcnt <= '0;
        end else begin
            if (r_state == S_IDLE && start) r_gap <= gap;
            if (r_state == S_RUN && w_state_nxt == S_GAP) begin
                r_gcnt <= r_gap;
            end else if (r_state == S_GAP) begin
                r_gcnt <= r_gcnt - GAP_W'(1);
            end
        end
    end
`endif

    assign cin      = (r_state == S_RUN);
    assign cnt_sclr = sclr | (r_state == S_CLR);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign aborted  = r_aborted;
    assign total    = {r_hi, cnt_q};

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: models the 4-bit counter IP, applies a table of jobs
// and checks pulse pattern, completion timing and final count.
module tb_counter_seq;

`ifdef CNT_SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic        clock;
    logic        sclr;
    logic        start;
    logic [11:0] len;
    logic [3:0]  gap;
    logic        abort;
    logic [3:0]  cnt_q;
    logic        cnt_cout;
    logic        cin;
    logic        cnt_sclr;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [11:0] total;

    counter_seq #(.CNT_W(4), .HI_W(8), .GAP_W(4)) dut (
        .clock    (clock),
        .sclr     (sclr),
        .start    (start),
        .len      (len),
        .gap      (gap),
        .abort    (abort),
        .cnt_q    (cnt_q),
        .cnt_cout (cnt_cout),
        .cin      (cin),
        .cnt_sclr (cnt_sclr),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .total    (total)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counter IP model: sync clear, count enable, combinational carry out.
    always_ff @(posedge clock) begin
        if (cnt_sclr)  cnt_q <= 4'd0;
        else if (cin)  cnt_q <= cnt_q + 4'd1;
    end
    assign cnt_cout = cin & (&cnt_q);

    typedef struct {
        int len;
        int gap;
        int abort_k;     // 1-based RUN cycle to abort in, 0 = none
        bit start_mid;   // extra start while busy
        bit poke_done;   // start + abort during the DONE cycle
        bit exp_abort;
        int exp_lat;     // cycles from start to done/aborted
        int exp_pulses;
        int exp_total;
    } vec_t;

    typedef struct {
        bit          is_abort;
        int          lat;
        int          pulses;
        logic [11:0] total;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int g, acyc, t_evt, npul;
        bit cin_bad, ctl_bad, ev_ab, both, ce, eb;
        logic [11:0] tot_evt;
        exp_t e;
        g     = GAP_ON ? v.gap : 0;
        acyc  = (v.abort_k > 0) ? 2 + (v.abort_k - 1) * (g + 1) : -1;
        e.is_abort = v.exp_abort;
        e.lat      = v.exp_lat;
        e.pulses   = v.exp_pulses;
        e.total    = 12'(v.exp_total);
        sb.push_back(e);
        t_evt = -1; npul = 0; cin_bad = 0; ctl_bad = 0; ev_ab = 0; both = 0;
        tot_evt = '0;
        for (int t = 0; t <= v.exp_lat + 8; t++) begin
            len   = (t == 0) ? 12'(v.len) : 12'd7;
            gap   = (t == 0) ? 4'(v.gap) : 4'd9;
            start = (t == 0) || (v.start_mid && t == 3) || (v.poke_done && t == v.exp_lat);
            abort = (t == acyc) || (v.poke_done && t == v.exp_lat);
            #1;
            ce = (t >= 2) && (((t - 2) % (g + 1)) == 0) &&
                 (v.exp_abort ? (t <= acyc) : (t < v.exp_lat));
            if (cin !== ce) cin_bad = 1'b1;
            if (cin) npul++;
            eb = (t >= 1) && ((t < v.exp_lat) || !v.exp_abort);
            if (busy !== eb || cnt_sclr !== (t == 1)) ctl_bad = 1'b1;
            if (done || aborted) begin
                t_evt   = t;
                ev_ab   = aborted && !done;
                both    = done && aborted;
                tot_evt = total;
                break;
            end
            @(posedge clock); #1;
        end
        // Cycle after completion: back in IDLE with total held.
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("post_busy", busy, 0);
        chk("post_pulse", done | aborted, 0);
        chk("post_total_hold", total, tot_evt);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("event_seen", t_evt >= 0, 1);
            chk("event_kind_aborted", ev_ab, e.is_abort);
            chk("done_and_aborted", both, 0);
            chk("latency", t_evt, e.lat);
            chk("pulses", npul, e.pulses);
            chk("total", tot_evt, e.total);
            chk("cin_pattern_err", cin_bad, 0);
            chk("busy_sclr_err", ctl_bad, 0);
        end
    endtask

    vec_t vt[9];

    initial begin
        //        len  gap ab  mid pk  exab lat                      pul   tot
        vt[0] = '{20,   0, 0,  0,  0,  0,   22,                      20,   20};
        vt[1] = '{0,    0, 0,  0,  0,  0,   2,                       0,    0};
        vt[2] = '{3,    2, 0,  0,  0,  0,   GAP_ON ? 9 : 5,          3,    3};
        vt[3] = '{20,   0, 5,  1,  0,  1,   7,                       5,    5};
        vt[4] = '{4095, 0, 0,  0,  0,  0,   4097,                    4095, 4095};
        vt[5] = '{1,    3, 0,  0,  1,  0,   3,                       1,    1};
        vt[6] = '{17,   1, 3,  0,  0,  1,   GAP_ON ? 7 : 5,          3,    3};
        vt[7] = '{5,    0, 1,  0,  0,  1,   3,                       1,    1};
        vt[8] = '{2,    1, 0,  0,  0,  0,   GAP_ON ? 5 : 4,          2,    2};

        // Reset held two cycles with start high: nothing may start.
        sclr = 1'b1; start = 1'b1; len = 12'd5; gap = 4'd0; abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            chk("rst_cnt_sclr", cnt_sclr, 1);
            chk("rst_outs", {busy, cin, done, aborted}, 0);
        end
        sclr = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        chk("rst_no_job", busy, 0);
        chk("rst_total", total, 0);

        foreach (vt[i]) run_job(vt[i]);

        // sclr mid-job, together with abort: job dies silently.
        len = 12'd10; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
        end
        chk("mid_cin_before", cin, 1);
        sclr = 1'b1; abort = 1'b1; #1;
        chk("mid_cnt_sclr", cnt_sclr, 1);
        @(posedge clock); #1;
        sclr = 1'b0; abort = 1'b0; #1;
        chk("mid_outs", {busy, cin, done, aborted}, 0);
        chk("mid_total", total, 0);
        @(posedge clock); #1;
        chk("mid_quiet", {busy, done, aborted}, 0);

        // Normal operation resumes after the mid-job reset.
        run_job(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
